// File: rtl/shared_adder_pkg.sv
// Shared definitions for the nibble-serial shared adder scheduler.
//   NIBBLE_W  : width of the shared adder slice (4 bits)
//   state_e   : scheduler FSM states (IDLE / ADD / DONE)
//   req_id_t  : identifies which requester owns an operation (0 or 1)
package shared_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/four_bit_adder.sv
// Purely combinational 4-bit ripple-carry adder, the shared datapath element.
// Ports:
//   a, b  : 4-bit operands
//   cin   : carry into bit 0
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[4];
  end

endmodule

// File: rtl/shared_adder_scheduler.sv
// Shares one four_bit_adder between two requesters. A granted operation is
// added one nibble per clock (LSB nibble first) with the carry chained
// through carry_q, then presented on the response port until taken.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqN_ready is combinational, only ever high in IDLE for the
// granted requester while it is valid, and never while rst is high. Once
// rsp_valid rises, rsp_sum/rsp_cout/rsp_id (and rsp_ovf) stay stable until
// the edge where rsp_ready is also high.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/cin      : requester N operands and handshake
//   rsp_valid/ready/sum/cout/id   : result, carry out of MSB nibble, owner id
//   rsp_ovf                       : signed overflow (only when
//                                   SHARED_ADDER_SCHEDULER_OVF_EN is defined)
//   dbg_state                     : current FSM state, for observation
//
// Build option: define SHARED_ADDER_SCHEDULER_OVF_EN to add rsp_ovf.
module shared_adder_scheduler
  import shared_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
  output logic             rsp_ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NUM_NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W       = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

  state_e           state_q, state_d;
  req_id_t          last_grant_q, last_grant_d;
  req_id_t          id_q, id_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  req_id_t               grant;
  logic                  accept;
  logic                  last_nibble;
  logic [NIBBLE_W-1:0]   add_a, add_b, add_sum;
  logic                  add_cout;

  // Round-robin: a lone requester wins; on a tie the one not granted last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Select the current nibble of the latched operands.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        add_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  four_bit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last_nibble = (idx_q == IDX_W'(NUM_NIBBLES - 1));
  assign accept      = req0_ready | req1_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = ADD;
          a_d          = grant ? req1_a   : req0_a;
          b_d          = grant ? req1_b   : req0_b;
          carry_d      = grant ? req1_cin : req0_cin;
          id_d         = grant;
          last_grant_d = grant;
          idx_d        = '0;
        end
      end
      ADD: begin
        for (int i = 0; i < NUM_NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = add_sum;
          end
        end
        carry_d = add_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nibble) begin
          state_d = DONE;
          cout_d  = add_cout;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
          // Carry into the MSB is a^b^sum at that bit; overflow when it
          // differs from the carry out.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_sum[NIBBLE_W-1] ^ add_cout;
`endif
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    req0_ready = !rst && (state_q == IDLE) && (grant == 1'b0) && req0_valid;
    req1_ready = !rst && (state_q == IDLE) && (grant == 1'b1) && req1_valid;
    rsp_valid  = (state_q == DONE);
    rsp_sum    = sum_q;
    rsp_cout   = cout_q;
    rsp_id     = id_q;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
    rsp_ovf    = ovf_q;
`endif
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Directed bench for shared_adder_scheduler: a WIDTH=16 instance driven by a
// vector table plus hand sequences, and a WIDTH=4 instance for the
// single-nibble case.
module tb_shared_adder_scheduler;

  localparam int W  = 16;
  localparam int NN = W / 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic         req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic         req0_ready, req1_ready, rsp_valid, rsp_cout, rsp_id;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_sum;
  logic         req0_cin = 0, req1_cin = 0;
  logic [1:0]   dbg_state;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
  logic         rsp_ovf;
`endif

  // WIDTH=4 instance
  logic       s_req0_valid = 0, s_req1_valid = 0, s_rsp_ready = 0;
  logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_cout, s_rsp_id;
  logic [3:0] s_req0_a = 0, s_req0_b = 0, s_req1_a = 0, s_req1_b = 0, s_rsp_sum;
  logic       s_req0_cin = 0, s_req1_cin = 0;
  logic [1:0] s_dbg_state;
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
  logic       s_rsp_ovf;
`endif

  shared_adder_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .dbg_state(dbg_state)
  );

  shared_adder_scheduler #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_cin(s_req0_cin),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_cin(s_req1_cin),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout), .rsp_id(s_rsp_id),
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
    .rsp_ovf(s_rsp_ovf),
`endif
    .dbg_state(s_dbg_state)
  );

  // scoreboard bookkeeping
  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q[$];  // {id, cout, sum}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  // Drive one request on the table's port, wait for the response, check it.
  task automatic run_vec(input vec_t v);
    int   lat;
    logic rdy;
    @(negedge clk);
    if (v.port == 1'b0) begin
      req0_a = v.a; req0_b = v.b; req0_cin = v.cin; req0_valid = 1'b1;
    end else begin
      req1_a = v.a; req1_b = v.b; req1_cin = v.cin; req1_valid = 1'b1;
    end
    rdy = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      rdy = v.port ? req1_ready : req0_ready;
      if (rdy) break;
      @(negedge clk);
    end
    chk("accept_ready", rdy, 1);
    chk("other_ready_low", v.port ? req0_ready : req1_ready, 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end while (!rsp_valid && lat < 30);
    chk("latency", lat, NN + 1);
    chk("sum", rsp_sum, v.sum);
    chk("cout", rsp_cout, v.cout);
    chk("id", rsp_id, v.port);
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
    chk("ovf", rsp_ovf, v.ovf);
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", dbg_state, 0);
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   viol;
    int   lat;
    logic [W+1:0] got, e;

    vecs[0] = '{port: 1'b0, a: 16'h1234, b: 16'h1111, cin: 1'b0, sum: 16'h2345, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{port: 1'b0, a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{port: 1'b1, a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{port: 1'b1, a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{port: 1'b0, a: 16'h00FF, b: 16'h0F01, cin: 1'b1, sum: 16'h1001, cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{port: 1'b1, a: 16'hABCD, b: 16'h1234, cin: 1'b1, sum: 16'hBE02, cout: 1'b0, ovf: 1'b0};

    // reset state, with requests pending during reset
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    s_req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_s_req0_ready", s_req0_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_state", dbg_state, 0);
    req0_valid = 1'b0; req1_valid = 1'b0; s_req0_valid = 1'b0;
    rst = 1'b0;

    // table-driven single operations
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // both requesters valid continuously: grants alternate 0,1,0,1
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 16'h0003});
    exp_q.push_back({1'b1, 1'b0, 16'h0300});
    exp_q.push_back({1'b0, 1'b0, 16'h0003});
    exp_q.push_back({1'b1, 1'b0, 16'h0300});
    req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    req1_a = 16'h0100; req1_b = 16'h0200; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) viol++;
      if ((req0_ready || req1_ready) && dbg_state != 2'd0) viol++;
      if (rsp_valid) begin
        got = {rsp_id, rsp_cout, rsp_sum};
        e = exp_q.pop_front();
        chk("alt_result", got, e);
        if (exp_q.size() == 0) break;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk("alt_all_responses", exp_q.size(), 0);
    chk("alt_ready_rules", viol, 0);

    // back-pressure: hold result in DONE for 10 cycles
    do_reset();
    @(negedge clk);
    req0_a = 16'h4321; req0_b = 16'h1111; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("bp_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, NN + 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    viol = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_sum !== 16'h5432 || rsp_id !== 1'b0 || rsp_cout !== 1'b0) viol++;
      if (req0_ready || req1_ready) viol++;
    end
    chk("bp_stable_stalled", viol, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_idle_next", dbg_state, 0);
    chk("bp_rsp_valid_drop", rsp_valid, 0);
    chk("bp_tie_req1_ready", req1_ready, 1);
    chk("bp_tie_req0_ready", req0_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // reset during 2nd ADD cycle abandons the operation
    do_reset();
    @(negedge clk);
    req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("rst_mid_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", dbg_state, 0);
    chk("rst_mid_sum", rsp_sum, 0);
    viol = 0;
    for (int n = 0; n < 10; n++) begin
      if (rsp_valid) viol++;
      @(negedge clk);
    end
    chk("rst_mid_no_rsp", viol, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_tie_req0", req0_ready, 1);
    chk("post_rst_tie_req1", req1_ready, 0);
    // reset and request in the same cycle: reset wins
    rst = 1'b1;
    #1;
    chk("rst_same_req0_ready", req0_ready, 0);
    chk("rst_same_req1_ready", req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst_same_not_accepted", dbg_state, 0);

    // WIDTH=4 instance: single ADD cycle
    @(negedge clk);
    s_req0_a = 4'h9; s_req0_b = 4'h8; s_req0_cin = 1'b1; s_req0_valid = 1'b1;
    #1;
    chk("w4_accept", s_req0_ready, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      s_req0_valid = 1'b0;
    end while (!s_rsp_valid && lat < 30);
    chk("w4_latency", lat, 2);
    chk("w4_sum", s_rsp_sum, 4'h2);
    chk("w4_cout", s_rsp_cout, 1);
    chk("w4_id", s_rsp_id, 0);
`ifdef SHARED_ADDER_SCHEDULER_OVF_EN
    chk("w4_ovf", s_rsp_ovf, 1);
`endif
    s_rsp_ready = 1'b1;
    @(negedge clk);
    s_rsp_ready = 1'b0;
    chk("w4_idle_after", s_dbg_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
